// File: rtl/cache_tag_lookup_sa_if.sv
// Lookup-side bundle of the set-associative tag/LRU controller: load/store lookup,
// memory fill handshake and maintenance controls.
interface cache_tag_lookup_sa_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned WAYS   = 4
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  logic              rd_rqst_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic              rd_byte_i;
  logic              wr_en_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic              kill_i;
  logic              inval_i;
  logic              rd_hit_o;
  logic              rd_miss_o;
  logic [WAY_W-1:0]  rd_hit_way_o;
  logic              wr_hit_o;
  logic [WAY_W-1:0]  wr_hit_way_o;
  logic [WAY_W-1:0]  victim_way_o;
  logic              fill_o;
  logic              rqst_to_mem_o;
  logic [ADDR_W-1:0] addr_to_mem_o;
  logic              unalign_o;
  logic              busy_o;

  modport slave (
    input  rd_rqst_i, rd_addr_i, rd_byte_i, wr_en_i, wr_addr_i,
    input  mem_ready_i, mem_addr_i, kill_i, inval_i,
    output rd_hit_o, rd_miss_o, rd_hit_way_o, wr_hit_o, wr_hit_way_o,
    output victim_way_o, fill_o, rqst_to_mem_o, addr_to_mem_o, unalign_o, busy_o
  );

  modport master (
    output rd_rqst_i, rd_addr_i, rd_byte_i, wr_en_i, wr_addr_i,
    output mem_ready_i, mem_addr_i, kill_i, inval_i,
    input  rd_hit_o, rd_miss_o, rd_hit_way_o, wr_hit_o, wr_hit_way_o,
    input  victim_way_o, fill_o, rqst_to_mem_o, addr_to_mem_o, unalign_o, busy_o
  );
endinterface

// File: rtl/cache_tag_lookup_sa.sv
// Set-associative tag/valid/LRU controller with matrix LRU per set and a
// single-outstanding miss FSM (idle -> wait for fill -> idle).
module cache_tag_lookup_sa #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned SET_W    = 2,
  parameter int unsigned WAYS     = 4
) (
  input logic                  clk_i,
  input logic                  rsn_i,
  cache_tag_lookup_sa_if.slave bus_io
);
  localparam int unsigned WAY_W = $clog2(WAYS);
  localparam int unsigned TAG_W = ADDR_W - OFFSET_W - SET_W;
  localparam int unsigned SETS  = 1 << SET_W;

  typedef logic [WAYS-1:0][WAYS-1:0] lru_t;
  typedef enum logic {StIdle, StWait} state_e;

  state_e            r_state;
  logic [WAYS-1:0]   r_valid [SETS];
  logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
  lru_t              r_lru   [SETS];
  logic [ADDR_W-1:0] r_miss_addr;
  logic              r_rqst;
  logic              r_fill;
  logic [WAY_W-1:0]  r_fill_way;

  logic [SET_W-1:0]  w_rd_set, w_wr_set, w_miss_set;
  logic [TAG_W-1:0]  w_rd_tag, w_wr_tag, w_miss_tag;
  logic [WAYS-1:0]   w_rd_match, w_wr_match;
  logic [WAY_W-1:0]  w_rd_way, w_wr_way, w_victim_pend, w_victim_rd;
  logic              w_unalign, w_rd_lookup, w_rd_hit, w_wr_hit, w_start_miss, w_fill;
  lru_t              w_lru_d [SETS];
  logic              w_unused;

  function automatic lru_t lru_reset();
    lru_t m;
    for (int i = 0; i < WAYS; i++) begin
      for (int j = 0; j < WAYS; j++) m[i][j] = (i < j);
    end
    return m;
  endfunction

  // Touched way becomes youngest: nobody is younger than it, everybody is older.
  function automatic lru_t lru_touch(input lru_t m, input logic [WAY_W-1:0] w);
    lru_t r;
    r = m;
    for (int i = 0; i < WAYS; i++) begin
      r[w][i] = 1'b0;
      r[i][w] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] first_one(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] res;
    res = '0;
    for (int i = WAYS - 1; i >= 0; i--) if (v[i]) res = WAY_W'(i);
    return res;
  endfunction

  function automatic logic [WAY_W-1:0] pick_victim(input logic [WAYS-1:0] v, input lru_t m);
    logic [WAYS-1:0] oldest;
    for (int i = 0; i < WAYS; i++) begin
      oldest[i] = 1'b1;
      for (int j = 0; j < WAYS; j++) if (j != i && !m[i][j]) oldest[i] = 1'b0;
    end
    return (&v) ? first_one(oldest) : first_one(~v);
  endfunction

  assign w_rd_set   = bus_io.rd_addr_i[OFFSET_W+SET_W-1:OFFSET_W];
  assign w_rd_tag   = bus_io.rd_addr_i[ADDR_W-1:OFFSET_W+SET_W];
  assign w_wr_set   = bus_io.wr_addr_i[OFFSET_W+SET_W-1:OFFSET_W];
  assign w_wr_tag   = bus_io.wr_addr_i[ADDR_W-1:OFFSET_W+SET_W];
  assign w_miss_set = r_miss_addr[OFFSET_W+SET_W-1:OFFSET_W];
  assign w_miss_tag = r_miss_addr[ADDR_W-1:OFFSET_W+SET_W];
  assign w_unused   = ^{bus_io.rd_addr_i[OFFSET_W-1:0], bus_io.wr_addr_i[OFFSET_W-1:0],
                        bus_io.mem_addr_i[OFFSET_W-1:0]};

  always_comb begin
    w_rd_match = '0;
    w_wr_match = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_rd_match[w] = r_valid[w_rd_set][w] && (r_tag[w_rd_set][w] == w_rd_tag);
      w_wr_match[w] = r_valid[w_wr_set][w] && (r_tag[w_wr_set][w] == w_wr_tag);
    end
  end

  assign w_unalign     = ~bus_io.rd_byte_i & (|bus_io.rd_addr_i[1:0]);
  assign w_rd_lookup   = (r_state == StIdle) & bus_io.rd_rqst_i & ~w_unalign;
  assign w_rd_hit      = w_rd_lookup & (|w_rd_match);
  assign w_wr_hit      = bus_io.wr_en_i & (|w_wr_match);
  assign w_rd_way      = first_one(w_rd_match);
  assign w_wr_way      = first_one(w_wr_match);
  assign w_start_miss  = w_rd_lookup & ~(|w_rd_match) & ~bus_io.inval_i;
  assign w_victim_pend = pick_victim(r_valid[w_miss_set], r_lru[w_miss_set]);
  assign w_victim_rd   = pick_victim(r_valid[w_rd_set], r_lru[w_rd_set]);
  assign w_fill        = (r_state == StWait) & bus_io.mem_ready_i & ~bus_io.kill_i &
                         ~bus_io.inval_i &
                         (bus_io.mem_addr_i[ADDR_W-1:OFFSET_W] == r_miss_addr[ADDR_W-1:OFFSET_W]);

  // Read (or fill) touch is applied before the store touch so the store way ends youngest.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      w_lru_d[s] = r_lru[s];
      if (w_rd_hit && w_rd_set == SET_W'(s)) w_lru_d[s] = lru_touch(w_lru_d[s], w_rd_way);
      if (w_fill && w_miss_set == SET_W'(s)) w_lru_d[s] = lru_touch(w_lru_d[s], w_victim_pend);
      if (w_wr_hit && w_wr_set == SET_W'(s)) w_lru_d[s] = lru_touch(w_lru_d[s], w_wr_way);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_state     <= StIdle;
      r_rqst      <= 1'b0;
      r_fill      <= 1'b0;
      r_fill_way  <= '0;
      r_miss_addr <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_lru[s]   <= lru_reset();
      end
    end else begin
      r_rqst <= w_start_miss;
      r_fill <= w_fill;
      if (w_fill) r_fill_way <= w_victim_pend;
      if (bus_io.inval_i) begin
        r_state <= StIdle;
        for (int s = 0; s < SETS; s++) begin
          r_valid[s] <= '0;
          r_lru[s]   <= lru_reset();
        end
      end else begin
        for (int s = 0; s < SETS; s++) r_lru[s] <= w_lru_d[s];
        case (r_state)
          StIdle: begin
            if (w_start_miss) begin
              r_state     <= StWait;
              r_miss_addr <= {bus_io.rd_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
          end
          StWait: begin
            if (bus_io.kill_i) begin
              r_state <= StIdle;
            end else if (w_fill) begin
              r_state                           <= StIdle;
              r_tag[w_miss_set][w_victim_pend]   <= w_miss_tag;
              r_valid[w_miss_set][w_victim_pend] <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus_io.rd_hit_o      = w_rd_hit;
  assign bus_io.rd_miss_o     = (r_state == StWait) ? bus_io.rd_rqst_i
                                                    : (w_rd_lookup & ~(|w_rd_match));
  assign bus_io.rd_hit_way_o  = w_rd_way;
  assign bus_io.wr_hit_o      = w_wr_hit;
  assign bus_io.wr_hit_way_o  = w_wr_way;
  // Hold the filled way during the fill_o pulse; otherwise show the live candidate.
  assign bus_io.victim_way_o  = r_fill ? r_fill_way
                              : ((r_state == StWait) ? w_victim_pend : w_victim_rd);
  assign bus_io.fill_o        = r_fill;
  assign bus_io.rqst_to_mem_o = r_rqst;
  assign bus_io.addr_to_mem_o = r_miss_addr;
  assign bus_io.unalign_o     = w_unalign;
  assign bus_io.busy_o        = (r_state != StIdle);
endmodule

// File: doc/cache_tag_lookup_sa.md
Name: cache_tag_lookup_sa

Overview:
- Parametrised set-associative tag/LRU controller for the data cache. Next generation of the 4-entry fully-associative lookup.
- Decodes set index and tag, reports read and write hits with way number, and selects a victim by per-set matrix LRU with invalid-way priority.
- Runs a single-outstanding miss FSM (request, wait, fill) and supports kill and whole-cache invalidate.
- Sits between the load/store stage and the memory interface. The data array is external and is indexed by the way and set outputs.

Parameters:
ADDR_W, 20, byte address width
OFFSET_W, 4, log2 line size in bytes
SET_W, 2, log2 number of sets (>=1)
WAYS, 4, associativity (2..8); WAY_W = $clog2(WAYS); TAG_W = ADDR_W-OFFSET_W-SET_W

Ports:
clk_i  in  1  clock
rsn_i  in  1  reset, synchronous, active-low
rd_rqst_i  in  1  read request
rd_addr_i  in  ADDR_W  read byte address
rd_byte_i  in  1  1 = byte access, 0 = word access
wr_en_i  in  1  store write enable
wr_addr_i  in  ADDR_W  store address
mem_ready_i  in  1  memory fill data valid
mem_addr_i  in  ADDR_W  address of returned line
kill_i  in  1  abort outstanding miss
inval_i  in  1  invalidate whole cache
rd_hit_o  out  1  read hit (combinational)
rd_miss_o  out  1  read cannot complete this cycle
rd_hit_way_o  out  WAY_W  way of read hit
wr_hit_o  out  1  store hit (combinational)
wr_hit_way_o  out  WAY_W  way of store hit
victim_way_o  out  WAY_W  way to be filled for pending miss
fill_o  out  1  one-cycle pulse: tag written this cycle
rqst_to_mem_o  out  1  one-cycle miss request pulse
addr_to_mem_o  out  ADDR_W  latched miss address, offset bits zeroed
unalign_o  out  1  word access with rd_addr_i[1:0]!=0
busy_o  out  1  state != IDLE

Behaviour:
Reset and address decode:
- Reset (rsn_i=0 at posedge) clears all valid bits, sets state to IDLE, and deasserts all registered outputs (rqst_to_mem_o, fill_o, busy_o, addr_to_mem_o=0).
- Each set's LRU matrix resets so that M[i][j]=1 iff i<j. Way 0 is LRU and way WAYS-1 is MRU.
- Address split: offset [OFFSET_W-1:0], set [OFFSET_W+SET_W-1:OFFSET_W], tag [ADDR_W-1:OFFSET_W+SET_W].

LRU:
- M[i][j]=1 means way i is older than way j.
- LRU way = the way whose row is all ones, ignoring the diagonal.
- Touching way w on a clock edge clears row w and sets column w. The diagonal is don't-care.
- Victim = lowest-index invalid way of the set if one exists, else the LRU way.

unalign_o:
- unalign_o = ~rd_byte_i & (|rd_addr_i[1:0]).
- An unaligned read does no lookup: rd_hit_o=0, rd_miss_o=0, no LRU update, no miss.

States:
- IDLE:
  - rd_hit_o = rd_rqst_i & aligned & (some valid way in the set has a matching tag); lowest matching way is reported.
  - A hit touches that way at the edge.
  - A miss raises rd_miss_o combinationally, latches the line address, pulses rqst_to_mem_o on the next cycle, and moves to WAIT.
- WAIT:
  - rd_hit_o=0; rd_miss_o=rd_rqst_i, so the pipeline stalls.
  - victim_way_o shows the victim of the pending set, evaluated live.
  - On mem_ready_i with mem_addr_i tag+set equal to the latched address:
    - write the tag into the victim way, set its valid bit, touch the way;
    - pulse fill_o with victim_way_o stable during that cycle;
    - return to IDLE.
  - A mem_ready_i with a mismatched address is ignored.
  - The re-issued read hits the cycle after the fill.

Stores:
- Write lookup is active in every state.
- wr_hit_o = wr_en_i & (tag match in a valid way of the store's set). A hit touches the way.
- A store miss is no-allocate and changes nothing.

Simultaneous events:
- Read hit and write hit in the same set, different ways: the read touch is applied first, then the write touch, so the write way ends MRU.
- Read hit and write hit on the same way: a single touch.
- A fill and a write hit in the same set on the same edge: fill touch first, then write touch.

Priority:
- reset > inval_i > kill_i > fill.
- inval_i clears all valid bits, resets all LRU matrices, and forces IDLE without fill_o. A pending rqst_to_mem_o pulse is still emitted if it was already scheduled.
- kill_i in WAIT returns to IDLE with no tag or valid change. kill_i in IDLE has no effect.
- A late mem_ready_i after kill_i or inval_i is ignored.

Timing:
- Hit latency 0 cycles (combinational hit, state update at edge).
- Miss-to-request latency 1 cycle.
- Only one miss is outstanding.

Test Plan:
1. Defaults, reset, read 0x00120 (set 2) -> rd_miss_o=1, next cycle rqst_to_mem_o=1 for exactly 1 cycle, addr_to_mem_o=0x00120, busy_o=1. Then mem_ready_i with mem_addr_i=0x00124 -> fill_o=1, victim_way_o=0. Next read 0x00124 -> rd_hit_o=1, way 0.
2. Fill set 0 with 0x00000, 0x00040, 0x00080, 0x000C0 -> ways 0, 1, 2, 3. Read hit 0x00000. Miss 0x00100 -> fills way 1, and 0x00040 then misses.
3. Miss 0x00200, assert kill_i in WAIT -> IDLE next cycle, no fill_o. Later mem_ready_i with mem_addr_i=0x00200 is ignored and a read of 0x00200 still misses.
4. Set 0 full as in scenario 2: in one cycle read hit way 1 and write hit way 2 -> way 2 MRU, way 1 second. Next miss in set 0 victimises way 3.
5. rd_byte_i=0, rd_addr_i=0x00122 -> unalign_o=1, rd_miss_o=0, no request. rd_byte_i=1 at the same address -> unalign_o=0 and a normal lookup.
6. Valid lines present, miss pending, assert inval_i -> busy_o=0 next cycle. All prior hit addresses now miss. Victim for any set = way 0.
